// File: rtl/restador_pkg.sv
// rtl/restador_pkg.sv - shared seven-segment constants and sizing helper
// Purpose: active-low segment encodings (bit 6 = g .. bit 0 = a), blank/minus
//          patterns, all-off anode pattern, and the nibble-count helper.
// Ports:   none (package).
package restador_pkg;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_A     = 7'b0001000;
   localparam logic [6:0] SEG_B     = 7'b0000011;
   localparam logic [6:0] SEG_C     = 7'b1000110;
   localparam logic [6:0] SEG_D     = 7'b0100001;
   localparam logic [6:0] SEG_E     = 7'b0000110;
   localparam logic [6:0] SEG_F     = 7'b0001110;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [7:0] AN_OFF    = 8'hFF;

   // Number of hex digits needed to show a width-bit magnitude.
   function automatic int nib_count(input int width);
      return (width + 3) / 4;
   endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex digit to active-low seven-segment decoder
// Purpose: maps a 4-bit value to its 0-F glyph.
// Ports:   hex - 4-bit value in
//          seg - 7-bit active-low segments out (seg[6]=g .. seg[0]=a)
module hex_to_seg7
   import restador_pkg::*;
(
   input  logic [3:0] hex,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_BLANK;
      case (hex)
         4'h0: seg = SEG_0;
         4'h1: seg = SEG_1;
         4'h2: seg = SEG_2;
         4'h3: seg = SEG_3;
         4'h4: seg = SEG_4;
         4'h5: seg = SEG_5;
         4'h6: seg = SEG_6;
         4'h7: seg = SEG_7;
         4'h8: seg = SEG_8;
         4'h9: seg = SEG_9;
         4'hA: seg = SEG_A;
         4'hB: seg = SEG_B;
         4'hC: seg = SEG_C;
         4'hD: seg = SEG_D;
         4'hE: seg = SEG_E;
         default: seg = SEG_F;
      endcase
   end

endmodule

// File: rtl/restador_disp_mux.sv
// rtl/restador_disp_mux.sv - |a-b| subtractor with multiplexed hex display scan
// Purpose: registers |a-b| and sign on load, scans the result across DIGITS
//          seven-segment digits (hex magnitude right, minus on the leftmost).
//          Optional leading-zero blanking: define RESTADOR_LZ_BLANK_EN.
// Ports:   clk       - clock, rising edge
//          rst_n     - asynchronous active-low reset
//          a, b      - WIDTH-bit unsigned minuend / subtrahend
//          load      - sample a and b at this edge
//          res_valid - one-cycle pulse after each load
//          seg       - registered active-low segments (seg[6]=g .. seg[0]=a)
//          dp        - decimal point, always off (high)
//          anodes    - registered active-low digit enables, bit 0 rightmost
module restador_disp_mux
   import restador_pkg::*;
#(
   parameter int WIDTH       = 8,
   parameter int DIGITS      = 4,
   parameter int REFRESH_DIV = 100000
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             load,
   output logic             res_valid,
   output logic [6:0]       seg,
   output logic             dp,
   output logic [7:0]       anodes
);

   localparam int NIB = nib_count(WIDTH);
   localparam int MW  = NIB * 4;
   localparam int PW  = $clog2(REFRESH_DIV);
   localparam logic [PW-1:0] PRE_LAST = PW'(REFRESH_DIV - 1);
   localparam logic [2:0]    IDX_LAST = 3'(DIGITS - 1);

   logic [MW-1:0]    mag;
   logic             sign;
   logic [PW-1:0]    presc;
   logic [2:0]       idx;
   logic [WIDTH-1:0] diff;
   logic [3:0]       nib;
   logic             show_mag;
   logic [6:0]       hex_seg;
   logic [6:0]       seg_next;
   logic [7:0]       an_next;

   assign diff = (a < b) ? (b - a) : (a - b);
   assign dp   = 1'b1;

   // Pick the nibble for the current digit; digits beyond the magnitude
   // leave show_mag low and fall through to blank.
   always_comb begin
      nib      = 4'h0;
      show_mag = 1'b0;
      for (int i = 0; i < NIB; i++) begin
         if (idx == 3'(i)) begin
            nib      = mag[i*4 +: 4];
            show_mag = 1'b1;
         end
      end
`ifdef RESTADOR_LZ_BLANK_EN
      begin : lz_blank
         logic [2:0] msn;
         msn = 3'd0;
         for (int i = 0; i < NIB; i++) begin
            if (mag[i*4 +: 4] != 4'h0) msn = 3'(i);
         end
         // idx 0 can never exceed msn, so the units digit always shows.
         if (idx > msn) show_mag = 1'b0;
      end
`endif
   end

   hex_to_seg7 u_hex (
      .hex (nib),
      .seg (hex_seg)
   );

   always_comb begin
      seg_next = SEG_BLANK;
      if (idx == IDX_LAST)
         seg_next = sign ? SEG_MINUS : SEG_BLANK;
      else if (show_mag)
         seg_next = hex_seg;
      an_next      = AN_OFF;
      an_next[idx] = 1'b0;
   end

   // Outputs are built from the pre-edge index/mag/sign, so a load coinciding
   // with a terminal count still shows the old result for that slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag       <= '0;
         sign      <= 1'b0;
         res_valid <= 1'b0;
         presc     <= '0;
         idx       <= 3'd0;
         anodes    <= AN_OFF;
         seg       <= SEG_BLANK;
      end else begin
         res_valid <= load;
         if (load) begin
            mag  <= MW'(diff);
            sign <= (a < b);
         end
         anodes <= an_next;
         seg    <= seg_next;
         if (presc == PRE_LAST) begin
            presc <= '0;
            idx   <= (idx == IDX_LAST) ? 3'd0 : idx + 3'd1;
         end else begin
            presc <= presc + PW'(1);
         end
      end
   end

endmodule

// File: doc/restador_disp_mux.md
RESTADOR_DISP_MUX -- requirements
Module: restador_disp_mux

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; legal range 2..28.
REQ-002 SHALL have parameter DIGITS, default 4: number of scanned display digits; legal range NIB+1..8, where NIB = ceil(WIDTH/4).
REQ-003 SHALL have parameter REFRESH_DIV, default 100000: clock cycles per digit slot; minimum 2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port a, input, WIDTH bits: minuend, unsigned.
REQ-007 SHALL have port b, input, WIDTH bits: subtrahend, unsigned.
REQ-008 SHALL have port load, input, 1 bit: when high at a clock edge, a and b are sampled.
REQ-009 SHALL have port res_valid, output, 1 bit: one-cycle pulse marking a new result.
REQ-010 SHALL have port seg, output, 7 bits: active-low segments, seg[6]=g down to seg[0]=a.
REQ-011 SHALL have port dp, output, 1 bit: decimal point, held high (off).
REQ-012 SHALL have port anodes, output, 8 bits: active-low digit enables; bit 0 is the rightmost digit.

Function
REQ-013 On a load edge, the block SHALL register mag = |a-b| (NIB*4 bits, zero-extended) and sign = (a<b).
REQ-014 a==b SHALL give mag=0 and sign=0; latency is 1 cycle, with res_valid high on the cycle after load.
REQ-015 load held high on consecutive cycles SHALL resample every cycle and pulse res_valid every cycle.
REQ-016 A prescaler SHALL count 0..REFRESH_DIV-1; at terminal count it wraps to 0 and the digit index advances.
REQ-017 The digit index SHALL advance 0,1,...,DIGITS-1 and wrap to 0.
REQ-018 seg and anodes SHALL be registered outputs, computed from the current index, mag and sign.
REQ-019 anodes SHALL drive bit[index] low and all other bits high; bits at or above DIGITS SHALL stay high.
REQ-020 Digit i < NIB SHALL show mag nibble i in hex (0-F); the encodings live in the package.
REQ-021 Digit DIGITS-1 SHALL show minus (0111111) when sign=1, and blank (1111111) otherwise.
REQ-022 Digits NIB..DIGITS-2 SHALL always be blank.
REQ-023 A load during a scan SHALL NOT reset the index or prescaler; the new value appears from the next refresh of each digit.
REQ-024 When load and a prescaler terminal count occur at the same edge, the output registered at that edge SHALL use the old mag and sign.

Reset
REQ-025 rst_n low SHALL asynchronously force: mag=0, sign=0, res_valid=0, prescaler=0, index=0, anodes=8'hFF, seg=7'h7F, dp=1.
REQ-026 On the first edge after release, the block SHALL drive anodes=8'hFE and seg to digit 0 ('0' = 1000000).
REQ-027 Reset mid-scan or mid-load SHALL discard the pending result with no res_valid pulse.

Configuration
REQ-028 Macro RESTADOR_LZ_BLANK_EN SHALL control leading-zero blanking.
REQ-029 With RESTADOR_LZ_BLANK_EN defined, magnitude digits above the most significant nonzero nibble SHALL be blank; digit 0 always shows, and the minus stays at DIGITS-1.
REQ-030 With RESTADOR_LZ_BLANK_EN undefined, all NIB magnitude digits SHALL show, including leading zeros.

Structure
REQ-031 Package restador_pkg SHALL hold: the seven-segment constants for hex 0-F, SEG_MINUS, SEG_BLANK and AN_OFF, plus a function computing NIB from WIDTH.
REQ-032 Sub-module hex_to_seg7 SHALL be used (4-bit in, 7-bit active-low out, combinational), instantiated once on the selected nibble.

Verification (WIDTH=8, DIGITS=4, REFRESH_DIV=4)
REQ-033 Scan: after reset release -> anodes sequence FE,FD,FB,F7,FE, changing every 4 cycles.
REQ-034 a=05, b=03, load -> res_valid next cycle; digit0 seg=0100100; digit1 seg=1000000 (blank with macro); digit3 blank.
REQ-035 a=03, b=05 -> digit0 shows '2' and digit3 seg=0111111.
REQ-036 a=b=7A -> mag=00, sign=0; digit0 shows '0' and digit3 is blank.
REQ-037 a=00, b=FF -> digits 0 and 1 seg=0001110 ('F') and digit3 shows minus.
REQ-038 rst_n low mid-scan -> anodes=FF and seg=7F immediately without a clock; after release the scan restarts at digit 0.
